// File: rtl/pong_pkg.sv
// Shared screen geometry, pixel/address types and the clear-FSM state encoding
// for the pong bitmap store.
package pong_pkg;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int COLOR_BITS = 3;

    typedef logic [COLOR_BITS-1:0] color_t;
    typedef logic [16:0]           pix_addr_t;

    localparam color_t CLEAR_COLOR_DEF = 3'b000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // row_w is always tied to a parameter, so this folds to shifts and adds.
    function automatic pix_addr_t pix_addr(input logic [8:0] px, input logic [7:0] py,
                                           input int row_w);
        return pix_addr_t'(int'(py) * row_w + int'(px));
    endfunction

endpackage

// File: rtl/pong_bitmap_store_ram.sv
// Simple dual-port pixel memory: one write port, one registered read-first read port.
module bitmap_dp_ram #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pong_bitmap_store.sv
// Pixel framebuffer with a pipelined read-back port and a full-frame clear engine.
// The clear sweep owns the RAM write port while busy; external writes are dropped then.
module pong_bitmap_store
    import pong_pkg::*;
#(
    parameter int                 WIDTH       = SCREEN_W,
    parameter int                 HEIGHT      = SCREEN_H,
    parameter int                 COLOR_W     = COLOR_BITS,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [8:0]         x,
    input  logic [7:0]         y,
    input  logic [COLOR_W-1:0] color,
    input  logic               rd_req,
    input  logic [8:0]         rd_x,
    input  logic [7:0]         rd_y,
    output logic               rd_valid,
    output logic [COLOR_W-1:0] rd_color,
    input  logic               clear_start,
    output logic               busy
);

    localparam int                NUM_PIX   = WIDTH * HEIGHT;
    localparam int                RAM_AW    = $clog2(NUM_PIX);
    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(NUM_PIX - 1);
    localparam logic [8:0]        X_LIM     = 9'(WIDTH);
    localparam logic [7:0]        Y_LIM     = 8'(HEIGHT);

    clr_state_t          state_q, state_d;
    logic [RAM_AW-1:0]   cnt_q, cnt_d;
    logic                wr_ok, rd_ok;
    logic [RAM_AW-1:0]   wr_pix, rd_pix;
    logic                wr_vld_q;
    logic [RAM_AW-1:0]   wr_addr_q;
    logic [COLOR_W-1:0]  wr_data_q;
    logic                rd_req_q, rd_ok_q, rd_req_q2, rd_ok_q2;
    logic [RAM_AW-1:0]   rd_addr_q;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [COLOR_W-1:0]  ram_wdata, ram_rdata;

    assign busy   = (state_q == ST_CLEAR);
    assign wr_pix = RAM_AW'(pix_addr(x, y, WIDTH));
    assign rd_pix = RAM_AW'(pix_addr(rd_x, rd_y, WIDTH));
    assign wr_ok  = wr_en && (x < X_LIM) && (y < Y_LIM) && (state_q == ST_IDLE) && !clear_start;
    assign rd_ok  = (rd_x < X_LIM) && (rd_y < Y_LIM);

    // The sweep bypasses the write pipeline so busy drops right after the last clear write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = wr_vld_q;
        ram_waddr = wr_addr_q;
        ram_wdata = wr_data_q;
        unique case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = CLEAR_COLOR;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RAM_AW'(1);
                end
            end
            default: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_ok_q   <= 1'b0;
            rd_req_q2 <= 1'b0;
            rd_ok_q2  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_color  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_vld_q  <= wr_ok;
            wr_addr_q <= wr_pix;
            wr_data_q <= color;
            rd_req_q  <= rd_req;
            rd_addr_q <= rd_pix;
            rd_ok_q   <= rd_ok;
            rd_req_q2 <= rd_req_q;
            rd_ok_q2  <= rd_ok_q;
            rd_valid  <= rd_req_q2;
            if (rd_req_q2) begin
                rd_color <= rd_ok_q2 ? ram_rdata : '0;
            end
        end
    end

    bitmap_dp_ram #(
        .DEPTH (NUM_PIX),
        .AW    (RAM_AW),
        .DW    (COLOR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_pong_bitmap_store.sv
// Directed bench for pong_bitmap_store. Uses full 320-pixel rows with a short frame
// height so each clear sweep stays a few thousand cycles.
module tb_pong_bitmap_store;

    localparam int TB_W    = 320;
    localparam int TB_H    = 16;
    localparam int NUM_PIX = TB_W * TB_H;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] x = '0;
    logic [7:0] y = '0;
    logic [2:0] color = '0;
    logic       rd_req = 1'b0;
    logic [8:0] rd_x = '0;
    logic [7:0] rd_y = '0;
    logic       rd_valid;
    logic [2:0] rd_color;
    logic       clear_start = 1'b0;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int n;

    pong_bitmap_store #(
        .WIDTH  (TB_W),
        .HEIGHT (TB_H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .x           (x),
        .y           (y),
        .color       (color),
        .rd_req      (rd_req),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_valid    (rd_valid),
        .rd_color    (rd_color),
        .clear_start (clear_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] wx, input logic [7:0] wy, input logic [2:0] wc);
        wr_en = 1'b1;
        x     = wx;
        y     = wy;
        color = wc;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [8:0] qx, input logic [7:0] qy,
                           input logic [2:0] exp);
        rd_req = 1'b1;
        rd_x   = qx;
        rd_y   = qy;
        tick();
        rd_req = 1'b0;
        tick();
        chk({tag, "_early"}, 32'(rd_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_color"}, 32'(rd_color), 32'(exp));
    endtask

    task automatic wait_sweep(input string tag);
        n = 0;
        while (busy && n < NUM_PIX + 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(NUM_PIX));
    endtask

    initial begin
        #2 reset = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_color", 32'(rd_color), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        wait_sweep("post_reset_sweep_len");
        do_read("rd_5_5", 9'd5, 8'd5, 3'b000);

        wr(9'd10, 8'd12, 3'b101);
        do_read("wr_then_rd", 9'd10, 8'd12, 3'b101);

        // Same-edge hazard: write and read (7,7) together, then read again next cycle.
        wr(9'd7, 8'd7, 3'b010);
        wr_en  = 1'b1;
        x      = 9'd7;
        y      = 8'd7;
        color  = 3'b111;
        rd_req = 1'b1;
        rd_x   = 9'd7;
        rd_y   = 8'd7;
        tick();
        wr_en = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("same_edge_early", 32'(rd_valid), 32'd0);
        tick();
        chk("same_edge_valid", 32'(rd_valid), 32'd1);
        chk("same_edge_old", 32'(rd_color), 32'd2);
        tick();
        chk("next_rd_valid", 32'(rd_valid), 32'd1);
        chk("next_rd_new", 32'(rd_color), 32'd7);
        tick();
        chk("pulse_end", 32'(rd_valid), 32'd0);

        wr(9'd319, 8'(TB_H - 1), 3'b011);
        do_read("corner", 9'd319, 8'(TB_H - 1), 3'b011);
        wr(9'd320, 8'd0, 3'b111);
        wr(9'd0, 8'(TB_H), 3'b111);
        do_read("oor_wr_alias", 9'd0, 8'd1, 3'b000);
        do_read("oor_wr_origin", 9'd0, 8'd0, 3'b000);
        do_read("oor_rd_x", 9'd320, 8'd0, 3'b000);
        do_read("oor_rd_y", 9'd10, 8'(TB_H + 1), 3'b000);

        // Clear together with a write; mid-sweep write and clear_start are both ignored.
        clear_start = 1'b1;
        wr(9'd1, 8'd1, 3'b110);
        clear_start = 1'b0;
        chk("clear_busy_rise", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < NUM_PIX + 100) begin
            wr_en       = (n == 1000);
            x           = 9'd2;
            y           = 8'd2;
            color       = 3'b101;
            clear_start = (n == 2000);
            tick();
            n++;
        end
        wr_en       = 1'b0;
        clear_start = 1'b0;
        chk("clear_len", 32'(n), 32'(NUM_PIX));
        wr(9'd3, 8'd3, 3'b100);
        do_read("first_idle_wr", 9'd3, 8'd3, 3'b100);
        do_read("cleared_1_1", 9'd1, 8'd1, 3'b000);
        do_read("busy_wr_drop", 9'd2, 8'd2, 3'b000);
        do_read("cleared_7_7", 9'd7, 8'd7, 3'b000);
        do_read("cleared_corner", 9'd319, 8'(TB_H - 1), 3'b000);

        // Reset 1000 cycles into a clear, with a read still in flight.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (999) tick();
        rd_req = 1'b1;
        rd_x   = 9'd3;
        rd_y   = 8'd3;
        tick();
        rd_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midclr_rst_busy", 32'(busy), 32'd1);
        tick();
        chk("midclr_rst_rd_valid", 32'(rd_valid), 32'd0);
        reset = 1'b0;
        tick();
        n = 1;
        while (busy && n < NUM_PIX + 100) begin
            tick();
            n++;
        end
        chk("midclr_restart_len", 32'(n), 32'(NUM_PIX));
        do_read("midclr_cleared", 9'd3, 8'd3, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
